gan_pixel_frame_loader: RTL and testbench

GAN_PIXEL_FRAME_LOADER -- requirements
Module: gan_pixel_frame_loader

---
 rtl/gan_pixel_frame_loader.sv | 112 +++++++++++
 tb/tb_gan_pixel_frame_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gan_pixel_frame_loader.sv
// Serial-bit to parallel Q8.8 frame loader feeding the GAN pipeline.
// Define GAN_LOADER_BIPOLAR_EN to store a 0 bit as -ONE_WORD instead of zero.
module gan_pixel_frame_loader #(
  parameter int          PIXEL_COUNT = 784,
  parameter logic [15:0] ONE_WORD    = 16'h0100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pixel_bit,
  input  logic                      pixel_bit_valid,
  output logic                      pixel_bit_ready,
  input  logic                      frame_consume,
  input  logic                      frame_abort,
  output logic [16*PIXEL_COUNT-1:0] frame_flat,
  output logic                      frame_ready,
  output logic [9:0]                pixel_index,
  output logic [9:0]                ones_count
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(PIXEL_COUNT - 1);

`ifdef GAN_LOADER_BIPOLAR_EN
  localparam logic [15:0] ZERO_WORD = 16'(~ONE_WORD + 16'd1);
`else
  localparam logic [15:0] ZERO_WORD = 16'h0000;
`endif

  state_t                    state_q, state_d;
  logic [9:0]                pixel_index_q, pixel_index_d;
  logic [9:0]                ones_count_q, ones_count_d;
  logic [16*PIXEL_COUNT-1:0] frame_q, frame_d;

  function automatic logic [15:0] pixel_word(input logic b);
    logic [15:0] w;
    if (b) begin
      w = ONE_WORD;
    end else begin
      w = ZERO_WORD;
    end
    return w;
  endfunction

  // Abort wins over everything else; ready is implied by being in LOAD.
  always_comb begin
    state_d       = state_q;
    pixel_index_d = pixel_index_q;
    ones_count_d  = ones_count_q;
    frame_d       = frame_q;
    if (frame_abort) begin
      state_d       = LOAD;
      pixel_index_d = 10'd0;
      ones_count_d  = 10'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (pixel_bit_valid) begin
            frame_d[{pixel_index_q, 4'b0000} +: 16] = pixel_word(pixel_bit);
            ones_count_d = ones_count_q + {9'd0, pixel_bit};
            if (pixel_index_q == LAST_IDX) begin
              state_d = FULL;
            end else begin
              pixel_index_d = pixel_index_q + 10'd1;
            end
          end else begin
            state_d = LOAD;
          end
        end
        FULL: begin
          if (frame_consume) begin
            state_d       = LOAD;
            pixel_index_d = 10'd0;
            ones_count_d  = 10'd0;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d       = LOAD;
          pixel_index_d = 10'd0;
          ones_count_d  = 10'd0;
        end
      endcase
    end
  end

  // State, counters and frame storage; reset clears the stored frame too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      pixel_index_q <= 10'd0;
      ones_count_q  <= 10'd0;
      frame_q       <= {(16*PIXEL_COUNT){1'b0}};
    end else begin
      state_q       <= state_d;
      pixel_index_q <= pixel_index_d;
      ones_count_q  <= ones_count_d;
      frame_q       <= frame_d;
    end
  end

  assign pixel_bit_ready = (state_q == LOAD);
  assign frame_ready     = (state_q == FULL);
  assign frame_flat      = frame_q;
  assign pixel_index     = pixel_index_q;
  assign ones_count      = ones_count_q;

endmodule

// File: tb/tb_gan_pixel_frame_loader.sv
// Scoreboard bench: a 4-pixel loader for the directed cases and a 784-pixel
// loader for the random frame. Expected words are queued as pixels are driven.
module tb_gan_pixel_frame_loader;

  localparam logic [15:0] ONE = 16'h0100;
`ifdef GAN_LOADER_BIPOLAR_EN
  localparam logic [15:0] ZW = 16'hFF00;
`else
  localparam logic [15:0] ZW = 16'h0000;
`endif
  localparam int BIGN = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_bit, s_valid, s_consume, s_abort;
  logic        s_ready, s_fready;
  logic [63:0] s_flat;
  logic [9:0]  s_idx, s_ones;

  logic                 l_rst, l_bit, l_valid, l_consume, l_abort;
  logic                 l_ready, l_fready;
  logic [16*BIGN-1:0]   l_flat;
  logic [9:0]           l_idx, l_ones;

  gan_pixel_frame_loader #(.PIXEL_COUNT(4), .ONE_WORD(ONE)) u_small (
    .clk(clk), .rst(s_rst), .pixel_bit(s_bit), .pixel_bit_valid(s_valid),
    .pixel_bit_ready(s_ready), .frame_consume(s_consume), .frame_abort(s_abort),
    .frame_flat(s_flat), .frame_ready(s_fready), .pixel_index(s_idx),
    .ones_count(s_ones)
  );

  gan_pixel_frame_loader #(.PIXEL_COUNT(BIGN), .ONE_WORD(ONE)) u_big (
    .clk(clk), .rst(l_rst), .pixel_bit(l_bit), .pixel_bit_valid(l_valid),
    .pixel_bit_ready(l_ready), .frame_consume(l_consume), .frame_abort(l_abort),
    .frame_flat(l_flat), .frame_ready(l_fready), .pixel_index(l_idx),
    .ones_count(l_ones)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mdl[4];
  int          mdl_idx;
  int          mdl_ones;

  int   rises = 0;
  logic l_fready_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic mdl_clear_frame();
    for (int i = 0; i < 4; i++) mdl[i] = 16'h0000;
    mdl_idx  = 0;
    mdl_ones = 0;
    exp_q.delete();
  endtask

  // One transfer on the small DUT; it must still be loading when this is called.
  task automatic send(input logic b);
    @(negedge clk);
    chk("ready_while_loading", {63'd0, s_ready}, 64'd1);
    chk("no_frame_yet", {63'd0, s_fready}, 64'd0);
    chk("index_while_loading", {54'd0, s_idx}, 64'(mdl_idx));
    s_valid = 1'b1;
    s_bit   = b;
    exp_q.push_back(b ? ONE : ZW);
    mdl[mdl_idx] = b ? ONE : ZW;
    mdl_ones += int'(b);
    if (mdl_idx < 3) mdl_idx++;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid   = 1'b0;
    s_consume = 1'b0;
    s_abort   = 1'b0;
    s_rst     = 1'b0;
  endtask

  task automatic check_full_frame();
    logic [63:0] e;
    e = 64'd0;
    chk("frame_ready", {63'd0, s_fready}, 64'd1);
    chk("ready_low_full", {63'd0, s_ready}, 64'd0);
    chk("ones_full", {54'd0, s_ones}, 64'(mdl_ones));
    chk("index_hold", {54'd0, s_idx}, 64'd3);
    for (int i = 0; i < 4; i++) e[16*i +: 16] = exp_q.pop_front();
    chk("frame_words", s_flat, e);
  endtask

  // Count rising edges of frame_ready on the large DUT.
  always @(negedge clk) begin
    if (l_fready && !l_fready_prev) rises <= rises + 1;
    l_fready_prev <= l_fready;
  end

  initial begin
    logic [63:0] held;
    int          sent;
    int          popc;
    logic        b;

    s_rst = 1'b1; s_bit = 1'b0; s_valid = 1'b0; s_consume = 1'b0; s_abort = 1'b0;
    l_rst = 1'b1; l_bit = 1'b0; l_valid = 1'b0; l_consume = 1'b0; l_abort = 1'b0;
    mdl_clear_frame();
    @(negedge clk);
    @(negedge clk);
    s_rst = 1'b0;
    l_rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_fready", {63'd0, s_fready}, 64'd0);
    chk("rst_index", {54'd0, s_idx}, 64'd0);
    chk("rst_ones", {54'd0, s_ones}, 64'd0);
    chk("rst_flat", s_flat, 64'd0);

    // Bits 1,0,1,1 back to back.
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    idle();
    check_full_frame();

    // Valid while full is ignored, then consume releases the frame.
    held = mdl_flat();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_bit   = 1'b0;
    end
    idle();
    chk("full_flat_stable", s_flat, held);
    chk("full_ones_stable", {54'd0, s_ones}, 64'd3);
    chk("full_still_ready", {63'd0, s_fready}, 64'd1);
    s_consume = 1'b1;
    idle();
    chk("consume_fready", {63'd0, s_fready}, 64'd0);
    chk("consume_ready", {63'd0, s_ready}, 64'd1);
    chk("consume_index", {54'd0, s_idx}, 64'd0);
    chk("consume_ones", {54'd0, s_ones}, 64'd0);
    chk("consume_retains", s_flat, held);
    mdl_idx = 0; mdl_ones = 0; exp_q.delete();

    // Abort together with a valid pixel after two pixels.
    send(1'b0); send(1'b1);
    @(negedge clk);
    s_valid = 1'b1; s_bit = 1'b0; s_abort = 1'b1;
    idle();
    chk("abort_index", {54'd0, s_idx}, 64'd0);
    chk("abort_ones", {54'd0, s_ones}, 64'd0);
    chk("abort_ready", {63'd0, s_ready}, 64'd1);
    chk("abort_dropped", s_flat, mdl_flat());
    mdl_idx = 0; mdl_ones = 0; exp_q.delete();

    // Reset after three pixels, then a clean frame.
    send(1'b1); send(1'b1); send(1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_bit = 1'b1; s_rst = 1'b1;
    idle();
    mdl_clear_frame();
    chk("mid_rst_flat", s_flat, 64'd0);
    chk("mid_rst_index", {54'd0, s_idx}, 64'd0);
    chk("mid_rst_ones", {54'd0, s_ones}, 64'd0);
    chk("mid_rst_fready", {63'd0, s_fready}, 64'd0);
    chk("mid_rst_ready", {63'd0, s_ready}, 64'd1);
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    idle();
    check_full_frame();

    // Zero-bit encoding: bits 0,1,0,0.
    s_consume = 1'b1;
    idle();
    mdl_idx = 0; mdl_ones = 0; exp_q.delete();
    send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    idle();
    chk("enc_fready", {63'd0, s_fready}, 64'd1);
    for (int i = 0; i < 4; i++) chk("enc_word", {48'd0, s_flat[16*i +: 16]}, {48'd0, exp_q.pop_front()});

    // 784 random bits with random gaps on the large loader.
    exp_q.delete();
    sent = 0;
    popc = 0;
    for (int cyc = 0; cyc < 20000 && sent < BIGN; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        b       = 1'($urandom_range(0, 1));
        l_valid = 1'b1;
        l_bit   = b;
        exp_q.push_back(b ? ONE : ZW);
        popc += int'(b);
        sent++;
      end else begin
        l_valid = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      l_valid = 1'b1;
      l_bit   = 1'b1;
    end
    @(negedge clk);
    l_valid = 1'b0;
    chk("big_fready", {63'd0, l_fready}, 64'd1);
    chk("big_ready_low", {63'd0, l_ready}, 64'd0);
    chk("big_ones", {54'd0, l_ones}, 64'(popc));
    chk("big_index", {54'd0, l_idx}, 64'(BIGN - 1));
    for (int i = 0; i < BIGN; i++) begin
      if (exp_q.size() == 0) begin
        chk("big_queue_short", 64'(i), 64'(BIGN));
        break;
      end
      chk("big_word", {48'd0, l_flat[16*i +: 16]}, {48'd0, exp_q.pop_front()});
    end
    l_consume = 1'b1;
    @(negedge clk);
    l_consume = 1'b0;
    @(negedge clk);
    chk("big_consumed", {63'd0, l_fready}, 64'd0);
    chk("big_rises", 64'(rises), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
